attack_arbiter: RTL

//   Owns combat state for the two-player fight. Arbitrates attack requests from
//   p1/p2 so that only one attack is in progress at a time. Applies damage to
//   the defender's shield or health and drives the p*_attack_grant, health,

---
 rtl/attack_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/attack_arbiter.sv
// Combat arbiter for the two-player fight: grants one attack at a time, applies
// damage to shield/health, regenerates shields per frame and flags the knockout.
module attack_arbiter #(
   parameter int MAX_HEALTH      = 10,
   parameter int MAX_SHIELD      = 10,
   parameter int GRANT_FRAMES    = 12,
   parameter int COOLDOWN_FRAMES = 30,
   parameter int REGEN_FRAMES    = 60
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       frame_tick,
   input  logic       restart,
   input  logic       p1_attack_req,
   input  logic       p2_attack_req,
   input  logic       p1_shield_req,
   input  logic       p2_shield_req,
   input  logic       p1_can_hit,
   input  logic       p2_can_hit,
   output logic       p1_attack_grant,
   output logic       p2_attack_grant,
   output logic [3:0] p1_health,
   output logic [3:0] p1_shield,
   output logic [3:0] p2_health,
   output logic [3:0] p2_shield,
   output logic [1:0] finish
);

   localparam logic [3:0] HEALTH_FULL = 4'(MAX_HEALTH);
   localparam logic [3:0] SHIELD_FULL = 4'(MAX_SHIELD);
   localparam logic [7:0] GRANT_LOAD  = 8'(GRANT_FRAMES);
   localparam logic [7:0] COOL_LOAD   = 8'(COOLDOWN_FRAMES);
   localparam logic [7:0] REGEN_LAST  = 8'(REGEN_FRAMES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      P1_ATK    = 3'd1,
      P2_ATK    = 3'd2,
      COOLDOWN  = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] frame_cnt, frame_cnt_nxt;
   logic [7:0] regen1, regen1_nxt;
   logic [7:0] regen2, regen2_nxt;
   logic       rr_p2, rr_p2_nxt;
   logic [3:0] health1_nxt, shield1_nxt, health2_nxt, shield2_nxt;
   logic [1:0] finish_nxt;
   logic       elig1, elig2, pick1, hit, dmg1, dmg2;

   function automatic logic [3:0] sat_dec(input logic [3:0] v);
      return (v == 4'd0) ? 4'd0 : v - 4'd1;
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v >= SHIELD_FULL) ? SHIELD_FULL : v + 4'd1;
   endfunction

   always_comb begin
      state_nxt     = state;
      frame_cnt_nxt = frame_cnt;
      rr_p2_nxt     = rr_p2;
      health1_nxt   = p1_health;
      shield1_nxt   = p1_shield;
      health2_nxt   = p2_health;
      shield2_nxt   = p2_shield;
      finish_nxt    = finish;
      regen1_nxt    = regen1;
      regen2_nxt    = regen2;
      dmg1          = 1'b0;
      dmg2          = 1'b0;
      elig1         = p1_attack_req & ~p1_shield_req;
      elig2         = p2_attack_req & ~p2_shield_req;
      pick1         = elig1 & (~elig2 | ~rr_p2);
      hit           = pick1 ? p1_can_hit : p2_can_hit;

      case (state)
         IDLE: begin
            if (elig1 | elig2) begin
               if (pick1) begin
                  if (hit) begin
                     dmg2 = 1'b1;
                     if (p2_shield_req && p2_shield != 4'd0) shield2_nxt = sat_dec(p2_shield);
                     else                                    health2_nxt = sat_dec(p2_health);
                  end
                  if (health2_nxt == 4'd0) begin
                     state_nxt  = GAME_OVER;
                     finish_nxt = 2'b01;
                  end else begin
                     state_nxt     = P1_ATK;
                     frame_cnt_nxt = GRANT_LOAD;
                     rr_p2_nxt     = 1'b1;
                  end
               end else begin
                  if (hit) begin
                     dmg1 = 1'b1;
                     if (p1_shield_req && p1_shield != 4'd0) shield1_nxt = sat_dec(p1_shield);
                     else                                    health1_nxt = sat_dec(p1_health);
                  end
                  if (health1_nxt == 4'd0) begin
                     state_nxt  = GAME_OVER;
                     finish_nxt = 2'b11;
                  end else begin
                     state_nxt     = P2_ATK;
                     frame_cnt_nxt = GRANT_LOAD;
                     rr_p2_nxt     = 1'b0;
                  end
               end
            end
         end
         P1_ATK, P2_ATK: begin
            if (frame_tick) begin
               if (frame_cnt <= 8'd1) begin
                  state_nxt     = COOLDOWN;
                  frame_cnt_nxt = COOL_LOAD;
               end else begin
                  frame_cnt_nxt = frame_cnt - 8'd1;
               end
            end
         end
         COOLDOWN: begin
            if (frame_tick) begin
               if (frame_cnt <= 8'd1) begin
                  state_nxt     = IDLE;
                  frame_cnt_nxt = 8'd0;
               end else begin
                  frame_cnt_nxt = frame_cnt - 8'd1;
               end
            end
         end
         GAME_OVER: begin
            if (restart) begin
               state_nxt   = IDLE;
               health1_nxt = HEALTH_FULL;
               health2_nxt = HEALTH_FULL;
               shield1_nxt = SHIELD_FULL;
               shield2_nxt = SHIELD_FULL;
               finish_nxt  = 2'b00;
               regen1_nxt  = 8'd0;
               regen2_nxt  = 8'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Shield regen; a player damaged this cycle loses the increment.
      if (state != GAME_OVER) begin
         if (p1_shield_req) begin
            regen1_nxt = 8'd0;
         end else if (frame_tick) begin
            if (regen1 >= REGEN_LAST) begin
               regen1_nxt = 8'd0;
               if (!dmg1) shield1_nxt = sat_inc(p1_shield);
            end else begin
               regen1_nxt = regen1 + 8'd1;
            end
         end
         if (p2_shield_req) begin
            regen2_nxt = 8'd0;
         end else if (frame_tick) begin
            if (regen2 >= REGEN_LAST) begin
               regen2_nxt = 8'd0;
               if (!dmg2) shield2_nxt = sat_inc(p2_shield);
            end else begin
               regen2_nxt = regen2 + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state           <= IDLE;
         frame_cnt       <= 8'd0;
         regen1          <= 8'd0;
         regen2          <= 8'd0;
         rr_p2           <= 1'b0;
         p1_attack_grant <= 1'b0;
         p2_attack_grant <= 1'b0;
         p1_health       <= HEALTH_FULL;
         p2_health       <= HEALTH_FULL;
         p1_shield       <= SHIELD_FULL;
         p2_shield       <= SHIELD_FULL;
         finish          <= 2'b00;
      end else begin
         state           <= state_nxt;
         frame_cnt       <= frame_cnt_nxt;
         regen1          <= regen1_nxt;
         regen2          <= regen2_nxt;
         rr_p2           <= rr_p2_nxt;
         p1_attack_grant <= (state_nxt == P1_ATK);
         p2_attack_grant <= (state_nxt == P2_ATK);
         p1_health       <= health1_nxt;
         p2_health       <= health2_nxt;
         p1_shield       <= shield1_nxt;
         p2_shield       <= shield2_nxt;
         finish          <= finish_nxt;
      end
   end

endmodule
